// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe
// Three-stage pipelined multiplier with a Wallace-tree reduction and
// valid/ready handshakes on both sides.
//   S1: partial-product bits, with Baugh-Wooley inversions in signed mode
//   S2: the two carry-save rows left after Wallace 3:2 / 2:2 compression
//   S3: carry-propagate sum, presented on result
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   in_valid / in_ready operand handshake; in_ready = ~out_valid | out_ready
//   input_a, input_b    WIDTH-bit operands
//   is_signed           1 = two's complement operands, 0 = unsigned
//   in_tag / out_tag    opaque sideband tag that travels with each operation
//   out_valid/out_ready result handshake
//   result              full 2*WIDTH-bit product
module wallace_mult_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     input_a,
    input  logic [WIDTH-1:0]     input_b,
    input  logic                 is_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int PW     = 2 * WIDTH;
    // One row per multiplier bit plus one row of Baugh-Wooley constants.
    localparam int ROWS   = WIDTH + 1;
    // Enough 3:2 levels to bring 33 rows (WIDTH=32) down to two.
    localparam int LEVELS = 8;
    // Signed correction: +2^WIDTH + 2^(2*WIDTH-1), taken modulo 2^(2*WIDTH).
    localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    logic             advance;

    logic [WIDTH-1:0] pp_next [WIDTH];
    logic             s1_valid;
    logic [WIDTH-1:0] s1_pp [WIDTH];
    logic             s1_signed;
    logic [TAG_W-1:0] s1_tag;

    logic [PW-1:0]    row_sum;
    logic [PW-1:0]    row_carry;
    logic             s2_valid;
    logic [PW-1:0]    s2_sum;
    logic [PW-1:0]    s2_carry;
    logic [TAG_W-1:0] s2_tag;

    // The whole pipe moves as one unit: it may shift whenever the output
    // slot is empty or is being consumed this cycle, so the input side can
    // accept in the same cycle the output side hands off.
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Partial-product bits.  In signed mode Baugh-Wooley inverts every bit
    // that pairs exactly one sign bit with a magnitude bit; the sign*sign
    // bit stays positive.  XOR-ing with the mode flag does the inversion.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp_next[i][j] = (input_a[j] & input_b[i]) ^
                                (is_signed & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
    end

    // Wallace reduction of the registered partial products.  Each level
    // groups the live rows in threes and replaces every group with a sum
    // row and a shifted carry row; the one or two leftover rows pass
    // through untouched.  Once two rows remain later levels do nothing.
    always_comb begin
        logic [PW-1:0] tree [ROWS];
        logic [PW-1:0] nxt  [ROWS];
        int cnt;
        int ncnt;
        int rem;
        int grp;

        for (int r = 0; r < ROWS; r++) begin
            nxt[r] = '0;
        end
        for (int r = 0; r < WIDTH; r++) begin
            tree[r] = PW'(s1_pp[r]) << r;
        end
        tree[WIDTH] = s1_signed ? BW_CONST : '0;
        cnt  = ROWS;
        ncnt = 0;
        rem  = 0;
        grp  = 0;

        for (int l = 0; l < LEVELS; l++) begin
            if (cnt > 2) begin
                for (int r = 0; r < ROWS; r++) begin
                    nxt[r] = '0;
                end
                grp = cnt / 3;
                for (int g = 0; g < ROWS / 3; g++) begin
                    if (g < grp) begin
                        nxt[2*g]   = tree[3*g] ^ tree[3*g+1] ^ tree[3*g+2];
                        nxt[2*g+1] = ((tree[3*g] & tree[3*g+1]) |
                                      (tree[3*g] & tree[3*g+2]) |
                                      (tree[3*g+1] & tree[3*g+2])) << 1;
                    end
                end
                rem  = cnt % 3;
                ncnt = 2 * grp;
                for (int r = 0; r < 2; r++) begin
                    if (r < rem) begin
                        nxt[ncnt+r] = tree[3*grp+r];
                    end
                end
                tree = nxt;
                cnt  = ncnt + rem;
            end
        end

        row_sum   = tree[0];
        row_carry = tree[1];
    end

    // Pipeline registers.  Valid bits always shift on advance so bubbles
    // flow; data registers only load behind a valid operation, which keeps
    // result at zero after reset until a real product arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_pp     <= '{default: '0};
            s1_signed <= 1'b0;
            s1_tag    <= '0;
            s2_valid  <= 1'b0;
            s2_sum    <= '0;
            s2_carry  <= '0;
            s2_tag    <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            out_tag   <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (in_valid) begin
                s1_pp     <= pp_next;
                s1_signed <= is_signed;
                s1_tag    <= in_tag;
            end
            if (s1_valid) begin
                s2_sum   <= row_sum;
                s2_carry <= row_carry;
                s2_tag   <= s1_tag;
            end
            if (s2_valid) begin
                result  <= s2_sum + s2_carry;
                out_tag <= s2_tag;
            end
        end
    end

endmodule

// File: doc/wallace_mult_pipe.md
WALLACE_MULT_PIPE -- requirements
Module: wallace_mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits; legal values are even integers from 8 to 32.
REQ-002 SHALL have parameter TAG_W, default 4: width of the sideband tag carried alongside each operation.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1: the operand set on the input ports is valid this cycle.
REQ-006 SHALL have port in_ready  output  1: the block accepts the operand set this cycle.
REQ-007 SHALL have port input_a  input  WIDTH: multiplicand.
REQ-008 SHALL have port input_b  input  WIDTH: multiplier.
REQ-009 SHALL have port is_signed  input  1: 1 selects two's-complement operands, 0 selects unsigned.
REQ-010 SHALL have port in_tag  input  TAG_W: opaque tag, returned unchanged with the result.
REQ-011 SHALL have port out_valid  output  1: result and out_tag are valid.
REQ-012 SHALL have port out_ready  input  1: the downstream consumer accepts the result this cycle.
REQ-013 SHALL have port result  output  2*WIDTH: full-width product.
REQ-014 SHALL have port out_tag  output  TAG_W: tag of the operation being presented.

Function
REQ-015 SHALL implement a fixed 3-stage pipeline:
- S1 registers the partial products; signed mode uses Baugh-Wooley sign handling.
- S2 registers the two rows left after Wallace-tree 3:2/2:2 compression.
- S3 registers the carry-propagate sum into result.
REQ-016 SHALL produce the result exactly 3 accepted-cycle advances after acceptance: latency is 3 clk cycles when not stalled.
REQ-017 SHALL compute result = input_a*input_b mod 2^(2*WIDTH), interpreting the operands as selected by is_signed; the result is exact, with no overflow possible.
REQ-018 SHALL accept an input when in_valid and in_ready are both 1 on a rising edge; is_signed and in_tag are captured together with the operands.
REQ-019 SHALL define advance = ~out_valid | out_ready and drive in_ready = advance combinationally.
REQ-020 SHALL shift all stages (data and per-stage valid bits) only when advance=1; when advance=0, every stage holds.
REQ-021 SHALL sustain a throughput of one operation per cycle when out_ready is held at 1.
REQ-022 SHALL keep result and out_tag stable while out_valid=1 and out_ready=0.
REQ-023 SHALL load an empty bubble into S1 when advance=1 and in_valid=0; bubbles SHALL never assert out_valid.
REQ-024 SHALL preserve transaction order, with no reordering or drop, in any combination of stalls and bubbles.
REQ-025 SHALL let a simultaneous output transfer (out_valid & out_ready) and input acceptance occur in the same cycle without loss.
REQ-026 SHALL allow is_signed to change on every transaction; each result uses the mode captured with its own operands.
REQ-027 SHALL hold the data in invalid stages without constraint (don't-care); only out_valid qualifies result.

Reset
REQ-028 SHALL, while rst=1, asynchronously clear all stage valid bits, out_valid=0, result=0 and out_tag=0.
REQ-029 SHALL, while rst=1, drive in_ready=1 (a consequence of out_valid=0), but accept no transaction while rst=1.
REQ-030 SHALL discard in-flight operations silently when rst is asserted mid-operation; none emerges after release.
REQ-031 SHALL accept a transaction on the first rising edge after rst deasserts.

Verification
REQ-032 SHALL cover unsigned, WIDTH=16, out_ready=1:
- 1408*1238 -> result=1743104, 3 cycles later.
- 10086*10086 -> result=101727396 on the following cycle.
REQ-033 SHALL cover the corners with WIDTH=16:
- unsigned 0xFFFF*0xFFFF -> 0xFFFE0001.
- signed 0xFFFF*0xFFFF (-1*-1) -> 0x00000001.
- signed 0x8000*0x8000 -> 0x40000000.
- signed 0x8000*0x0001 -> 0xFFFF8000.
REQ-034 SHALL cover back-to-back mixed modes: tags 1..4 issued on consecutive cycles with alternating is_signed -> out_tag sequence 1,2,3,4 on consecutive cycles, each result correct for its own mode.
REQ-035 SHALL cover backpressure:
- Three operations issued, then out_ready=0 for 5 cycles -> out_valid held with the first result stable and in_ready=0.
- out_ready=1 -> the three results drain on consecutive cycles.
REQ-036 SHALL cover reset mid-flight: rst pulsed 1 cycle after two acceptances -> out_valid never asserts for them and result=0; a new 7*9 issued after release -> 63.
REQ-037 SHALL cover random regression: 100000 random operands per WIDTH in {8,16,32}, random is_signed, random out_ready -> every result matches the reference model, zero mismatches.
